// File: rtl/adc_sample_scheduler.sv
// Runs one ADC conversion round per sample period (assistance, then phase voltage), updates both
// outputs atomically, pulses LoopStrobe per fresh pair and flags a hung converter. Optional: ADC_AVERAGE_EN.
module adc_sample_scheduler #(
  parameter int SAMPLE_DIV = 128,
  parameter int TIMEOUT    = 16
) (
  input  logic        c20k,
  input  logic        nReset,
  input  logic        Enable,
  output logic        AdcStart,
  output logic        AdcChannel,
  input  logic        AdcDone,
  input  logic [11:0] AdcData,
  output logic [11:0] AssistanceRequirement,
  output logic [11:0] PhaseWireVoltage,
  output logic        LoopStrobe,
  output logic        AdcFault
);

  localparam int             PW           = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0]  PERIOD_LAST  = PW'(SAMPLE_DIV - 1);
  localparam logic [7:0]     TIMEOUT_LAST = 8'(TIMEOUT - 1);

  // SWITCH gives the channel mux one settling cycle before the second request.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    SWITCH = 3'd3,
    DONE   = 3'd4
  } stateT;

  stateT         stateR;
  stateT         nextStateS;
  logic [PW-1:0] periodCountR;
  logic [7:0]    toCountR;
  logic [11:0]   assistShadowR;
  logic          tickS;
  logic          captureS;
  logic          timeoutS;
  logic          lastConvS;
  logic [11:0]   sampleS;

`ifdef ADC_AVERAGE_EN
  logic [1:0]  convIdxR;
  logic [13:0] sumR;
  logic [13:0] sumNextS;

  // Running sum including the conversion completing this cycle.
  always_comb begin
    sumNextS = sumR + {2'b00, AdcData};
  end

  assign lastConvS = (convIdxR == 2'd3);
  assign sampleS   = sumNextS[13:2];

  // Per-channel accumulator; cleared after the fourth sample or on an aborted round.
  always_ff @(posedge c20k) begin
    if (!nReset) begin
      convIdxR <= 2'd0;
      sumR     <= 14'd0;
    end else if (captureS) begin
      convIdxR <= convIdxR + 2'd1;
      if (lastConvS) begin
        sumR <= 14'd0;
      end else begin
        sumR <= sumNextS;
      end
    end else if (timeoutS) begin
      convIdxR <= 2'd0;
      sumR     <= 14'd0;
    end else begin
      convIdxR <= convIdxR;
      sumR     <= sumR;
    end
  end
`else
  assign lastConvS = 1'b1;
  assign sampleS   = AdcData;
`endif

  assign tickS = (periodCountR == PERIOD_LAST);

  // Free-running sample period counter, independent of Enable and FSM state.
  always_ff @(posedge c20k) begin
    if (!nReset) begin
      periodCountR <= {PW{1'b0}};
    end else if (tickS) begin
      periodCountR <= {PW{1'b0}};
    end else begin
      periodCountR <= periodCountR + PW'(1);
    end
  end

  // Next-state decode for the conversion sequencer.
  always_comb begin
    nextStateS = stateR;
    captureS   = 1'b0;
    timeoutS   = 1'b0;
    case (stateR)
      IDLE: begin
        if (tickS && Enable) begin
          nextStateS = START;
        end else begin
          nextStateS = IDLE;
        end
      end
      START: nextStateS = WAIT;
      WAIT: begin
        if (AdcDone) begin
          captureS = 1'b1;
          if (!lastConvS) begin
            nextStateS = START;
          end else if (!AdcChannel) begin
            nextStateS = SWITCH;
          end else begin
            nextStateS = DONE;
          end
        end else if (toCountR == TIMEOUT_LAST) begin
          timeoutS   = 1'b1;
          nextStateS = IDLE;
        end else begin
          nextStateS = WAIT;
        end
      end
      SWITCH:  nextStateS = START;
      DONE:    nextStateS = IDLE;
      default: nextStateS = IDLE;
    endcase
  end

  // State register plus request/strobe/fault outputs and the conversion watchdog.
  always_ff @(posedge c20k) begin
    if (!nReset) begin
      stateR     <= IDLE;
      AdcStart   <= 1'b0;
      AdcChannel <= 1'b0;
      LoopStrobe <= 1'b0;
      AdcFault   <= 1'b0;
      toCountR   <= 8'd0;
    end else begin
      stateR     <= nextStateS;
      AdcStart   <= (nextStateS == START);
      LoopStrobe <= (nextStateS == DONE);
      if (stateR == WAIT) begin
        toCountR <= toCountR + 8'd1;
      end else begin
        toCountR <= 8'd0;
      end
      if (stateR == IDLE) begin
        AdcChannel <= 1'b0;
      end else if (nextStateS == SWITCH) begin
        AdcChannel <= 1'b1;
      end else begin
        AdcChannel <= AdcChannel;
      end
      if (timeoutS) begin
        AdcFault <= 1'b1;
      end else begin
        AdcFault <= AdcFault;
      end
    end
  end

  // Assistance waits in a shadow; both outputs load on the edge entering DONE.
  always_ff @(posedge c20k) begin
    if (!nReset) begin
      assistShadowR         <= 12'd0;
      AssistanceRequirement <= 12'd0;
      PhaseWireVoltage      <= 12'd0;
    end else if (captureS && lastConvS && !AdcChannel) begin
      assistShadowR         <= sampleS;
      AssistanceRequirement <= AssistanceRequirement;
      PhaseWireVoltage      <= PhaseWireVoltage;
    end else if (captureS && lastConvS && AdcChannel) begin
      assistShadowR         <= assistShadowR;
      AssistanceRequirement <= assistShadowR;
      PhaseWireVoltage      <= sampleS;
    end else begin
      assistShadowR         <= assistShadowR;
      AssistanceRequirement <= AssistanceRequirement;
      PhaseWireVoltage      <= PhaseWireVoltage;
    end
  end

endmodule

// File: doc/adc_sample_scheduler.md
# adc_sample_scheduler

Sequences the single shared motor-board ADC between the two quantities the current loop consumes: torque-sensor assistance demand and phase-wire voltage. Once per sample period it runs one conversion round (assistance, then phase voltage), latches both 12-bit results, and pulses a loop-update strobe. That strobe lets the current controller update exactly once per fresh sample pair instead of on a free-running divider. It also watches for a hung converter and raises a sticky fault.

## Interface
- SAMPLE_DIV, 128: c20k cycles per sample period; legal range 8..4096.
- TIMEOUT, 16: maximum cycles from AdcStart to AdcDone before the conversion is declared failed; legal range 2..255.

- c20k  in  1  system clock; all logic on its rising edge.
- nReset  in  1  synchronous, active-low reset.
- Enable  in  1  permits new conversion rounds.
- AdcStart  out  1  one-cycle request to the converter.
- AdcChannel  out  1  0 = assistance (torque sensor), 1 = phase-wire voltage; stable from AdcStart through AdcDone.
- AdcDone  in  1  one-cycle completion pulse from the converter.
- AdcData  in  12  conversion result, valid when AdcDone = 1.
- AssistanceRequirement  out  12  last good assistance sample.
- PhaseWireVoltage  out  12  last good phase-voltage sample.
- LoopStrobe  out  1  one-cycle pulse when both outputs hold samples from the same completed round.
- AdcFault  out  1  sticky converter-timeout flag.

## Operation
- Period counter: free-runs 0..SAMPLE_DIV-1 and wraps to 0. Tick = counter at SAMPLE_DIV-1. The counter runs regardless of Enable or FSM state.
- FSM states:
  - IDLE: on tick with Enable = 1, set AdcChannel = 0 and go to START.
  - START: AdcStart = 1 for this cycle only; clear the timeout counter; go to WAIT.
  - WAIT: count cycles.
    - AdcDone = 1: capture AdcData into the channel's holding register. Channel 0 goes to START with AdcChannel = 1. Channel 1 goes to DONE.
    - Counter reaches TIMEOUT without AdcDone: set AdcFault and go to IDLE. Abort the round; neither output register changes for the aborted channel; no LoopStrobe.
  - DONE: LoopStrobe = 1 for one cycle; go to IDLE.
- Output update is atomic. Captured values sit in shadow registers. On entry to DONE, AssistanceRequirement and PhaseWireVoltage update together, so a partially completed round never reaches the outputs.
- Boundary behaviour:
  - Ticks outside IDLE are dropped; there is no queueing.
  - AdcDone outside WAIT is ignored.
  - AdcDone in the same cycle the timeout expires counts as success.
  - Enable falling mid-round: the round completes normally; no new round starts.
  - nReset low mid-round: aborts immediately, returns to IDLE next edge.
  - AdcFault clears only on reset. Rounds continue after a fault, so a recovered converter resumes normal operation.

## Timing
- Reset values: AdcStart 0, AdcChannel 0, AssistanceRequirement 0, PhaseWireVoltage 0, LoopStrobe 0, AdcFault 0, period counter 0, FSM IDLE.
- Tick at edge T: AdcStart high in cycle T+1 (START).
- Converter done d cycles after AdcStart (1 ≤ d ≤ TIMEOUT): the second AdcStart is 2 cycles after the first AdcDone.
- LoopStrobe and the updated outputs are visible in the cycle after the second AdcDone. The outputs change on the same edge LoopStrobe rises.
- Minimum round time with d = 1, averaging off: 6 cycles. SAMPLE_DIV must exceed the worst-case round of 2·(TIMEOUT+2)+2 cycles to avoid dropped ticks; with defaults that is 38 < 128.
- AdcFault rises the cycle after the timeout count hits TIMEOUT.

## Configuration
- ADC_AVERAGE_EN defined:
  - Each channel is converted 4 times back-to-back: channel 0 ×4, then channel 1 ×4.
  - Each channel accumulates into a 14-bit unsigned sum. The output is sum[13:2], i.e. truncating divide by 4; no rounding.
  - A timeout on any conversion aborts the whole round.
  - LoopStrobe fires after the 8th AdcDone.
- ADC_AVERAGE_EN undefined: one conversion per channel, as above; no accumulator logic.

## Test plan
- Reset with nReset = 0 for 3 cycles, then release, Enable = 0 for 300 cycles -> all outputs 0, no AdcStart.
- Enable = 1, converter model returns 12'h800 (ch0) / 12'h3FF (ch1) with d = 3 -> AdcStart at cycles T+1 and T+6; LoopStrobe at T+10; outputs 12'h800 / 12'h3FF; one round per 128 cycles.
- Converter never answers the first ch1 request -> AdcFault = 1 exactly TIMEOUT+1 cycles after that AdcStart; outputs keep the previous round's values; no LoopStrobe; the next tick starts a new round.
- Spurious AdcDone in IDLE carrying 12'hFFF -> ignored; outputs unchanged.
- nReset = 0 during WAIT on ch1 -> next cycle FSM IDLE, all outputs 0, AdcFault 0.
- ADC_AVERAGE_EN defined, ch0 samples 100, 101, 102, 104 -> AssistanceRequirement = 101 (407 >> 2); LoopStrobe after the 8th AdcDone.
